// File: rtl/wb_echo_capture.sv
// rtl/wb_echo_capture.sv - Wishbone echo pulse-width capture slave with timeout, overrun and level irq.
// Optional glitch filter on the synchronized echo when ECHO_GLITCH_FILTER_EN is defined.
module wb_echo_capture #(
  parameter logic [31:0] timeout_default = 32'd3000000,
  parameter int          filter_len      = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  output logic        wb_ack_o,
  input  logic        trig_i,
  input  logic        echo_i,
  output logic        intr
);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_MEASURE, S_HOLDOFF} state_t;

  state_t      r_state, w_state_nxt;
  logic        r_echo_m, r_echo_s, r_echo_d, r_trig_d;
  logic        r_ack, r_enable, r_irq_en, r_valid, r_tmo_flag, r_overrun, r_intr;
  logic [31:0] r_dat, r_width, r_cnt, r_elapsed, r_tmo_reg;
  logic        w_echo, w_rise, w_fall, w_busy, w_req, w_wr;
  logic        w_wr_status, w_wr_ctrl, w_wr_tmo, w_en_eff, w_arm_req, w_tmo_hit;
  logic        w_arm, w_start, w_done, w_tmo, w_clr_valid, w_clr_tmo, w_clr_ovr;
  logic [31:0] w_rdata;
  logic        w_unused;

  assign w_unused = ^{wb_sel_i, wb_adr_i[31:4], wb_adr_i[1:0]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_echo_m <= 1'b0;
      r_echo_s <= 1'b0;
      r_echo_d <= 1'b0;
      r_trig_d <= 1'b0;
    end else begin
      r_echo_m <= echo_i;
      r_echo_s <= r_echo_m;
      r_echo_d <= w_echo;
      r_trig_d <= trig_i;
    end
  end

`ifdef ECHO_GLITCH_FILTER_EN
  localparam logic [7:0] FILT_MAX = 8'(filter_len - 1);
  logic       r_filt;
  logic [7:0] r_fcnt;

  // Level follows the synchronized echo only after filter_len consecutive disagreeing samples.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_filt <= 1'b0;
      r_fcnt <= 8'd0;
    end else if (r_echo_s != r_filt) begin
      if (r_fcnt == FILT_MAX) begin
        r_filt <= r_echo_s;
        r_fcnt <= 8'd0;
      end else begin
        r_fcnt <= r_fcnt + 8'd1;
      end
    end else begin
      r_fcnt <= 8'd0;
    end
  end
  assign w_echo = r_filt;
`else
  assign w_echo = r_echo_s;
`endif

  assign w_rise = w_echo & ~r_echo_d;
  assign w_fall = ~w_echo & r_echo_d;
  assign w_busy = (r_state != S_IDLE);

  assign w_req       = wb_stb_i & wb_cyc_i;
  assign w_wr        = w_req & wb_we_i & r_ack;
  assign w_wr_status = w_wr & (wb_adr_i[3:2] == 2'd0);
  assign w_wr_ctrl   = w_wr & (wb_adr_i[3:2] == 2'd2);
  assign w_wr_tmo    = w_wr & (wb_adr_i[3:2] == 2'd3);
  assign w_clr_valid = w_wr_status & wb_dat_i[1];
  assign w_clr_tmo   = w_wr_status & wb_dat_i[2];
  assign w_clr_ovr   = w_wr_status & wb_dat_i[3];

  // A CTRL write in progress is honoured in the same cycle for both arm and abort.
  assign w_en_eff  = w_wr_ctrl ? wb_dat_i[0] : r_enable;
  assign w_arm_req = (r_trig_d & ~trig_i) | (w_wr_ctrl & wb_dat_i[2]);
  assign w_tmo_hit = (r_tmo_reg != 32'd0) &&
                     (({1'b0, r_elapsed} + 33'd1) >= {1'b0, r_tmo_reg});

  always_comb begin
    w_state_nxt = r_state;
    w_arm       = 1'b0;
    w_start     = 1'b0;
    w_done      = 1'b0;
    w_tmo       = 1'b0;
    if (!w_en_eff) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (w_arm_req) begin
          w_state_nxt = S_ARMED;
          w_arm       = 1'b1;
        end
        S_ARMED: if (w_rise) begin
          w_state_nxt = S_MEASURE;
          w_start     = 1'b1;
        end else if (w_tmo_hit) begin
          w_state_nxt = S_HOLDOFF;
          w_tmo       = 1'b1;
        end
        S_MEASURE: if (w_fall) begin
          w_state_nxt = S_IDLE;
          w_done      = 1'b1;
        end else if (w_tmo_hit) begin
          w_state_nxt = S_HOLDOFF;
          w_tmo       = 1'b1;
        end
        S_HOLDOFF: if (!w_echo) w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_rdata = 32'd0;
    case (wb_adr_i[3:2])
      2'd0: w_rdata = {28'd0, r_overrun, r_tmo_flag, r_valid, w_busy};
      2'd1: w_rdata = r_width;
      2'd2: w_rdata = {30'd0, r_irq_en, r_enable};
      2'd3: w_rdata = r_tmo_reg;
      default: w_rdata = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_ack      <= 1'b0;
      r_dat      <= 32'd0;
      r_enable   <= 1'b0;
      r_irq_en   <= 1'b0;
      r_tmo_reg  <= timeout_default;
      r_width    <= 32'd0;
      r_cnt      <= 32'd0;
      r_elapsed  <= 32'd0;
      r_valid    <= 1'b0;
      r_tmo_flag <= 1'b0;
      r_overrun  <= 1'b0;
      r_intr     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ack   <= w_req & ~r_ack;
      if (w_req && !r_ack) r_dat <= w_rdata;
      if (w_wr_ctrl) begin
        r_enable <= wb_dat_i[0];
        r_irq_en <= wb_dat_i[1];
      end
      if (w_wr_tmo) r_tmo_reg <= wb_dat_i;
      if (w_arm) r_elapsed <= 32'd0;
      else if ((r_state == S_ARMED || r_state == S_MEASURE) && r_elapsed != 32'hFFFF_FFFF)
        r_elapsed <= r_elapsed + 32'd1;
      if (w_start) r_cnt <= 32'd1;
      else if (r_state == S_MEASURE && w_echo && r_cnt != 32'hFFFF_FFFF)
        r_cnt <= r_cnt + 32'd1;
      if (w_done) r_width <= r_cnt;
      r_valid    <= w_done | (r_valid & ~w_clr_valid);
      r_tmo_flag <= w_tmo | (r_tmo_flag & ~w_clr_tmo);
      r_overrun  <= (w_done & r_valid) | (r_overrun & ~w_clr_ovr);
      r_intr     <= r_irq_en & (r_valid | r_tmo_flag);
    end
  end

  assign wb_dat_o = r_dat;
  assign wb_ack_o = r_ack;
  assign intr     = r_intr;

endmodule

// File: tb/tb_wb_echo_capture.sv
// tb/tb_wb_echo_capture.sv - self-checking bench for wb_echo_capture: vector table, hand sequences, random vs model.
module tb_wb_echo_capture;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] wb_adr_i = '0, wb_dat_i = '0, wb_dat_o;
  logic        wb_stb_i = 1'b0, wb_cyc_i = 1'b0, wb_we_i = 1'b0, wb_ack_o;
  logic [3:0]  wb_sel_i = 4'hF;
  logic        trig_i = 1'b0, echo_i = 1'b0, intr;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [31:0] A_STATUS = 32'h7000_0000;
  localparam logic [31:0] A_WIDTH  = 32'h7000_0004;
  localparam logic [31:0] A_CTRL   = 32'h7000_0008;
  localparam logic [31:0] A_TMO    = 32'h7000_000C;

  wb_echo_capture dut (
    .clk(clk), .reset(reset),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i), .wb_we_i(wb_we_i),
    .wb_sel_i(wb_sel_i), .wb_ack_o(wb_ack_o),
    .trig_i(trig_i), .echo_i(echo_i), .intr(intr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned width;
    bit          clear;
    logic [31:0] exp_width;
    logic [31:0] exp_status;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wb_xfer(input logic [31:0] a, input logic we, input logic [31:0] wd,
                         output logic [31:0] rd);
    int n;
    tick(1);
    wb_adr_i = a; wb_we_i = we; wb_dat_i = wd; wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
    n = 0;
    do begin
      tick(1);
      n++;
    end while (!wb_ack_o && n < 10);
    if (!wb_ack_o) begin
      n_checks++;
      n_errors++;
      $display("FAIL wb_ack_timeout: got no ack expected ack within 10 cycles");
    end
    rd = wb_dat_o;
    tick(1);
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] junk;
    wb_xfer(a, 1'b1, d, junk);
  endtask

  task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    wb_xfer(a, 1'b0, 32'd0, d);
    chk(name, d, exp);
  endtask

  task automatic trig_pulse();
    trig_i = 1'b1;
    tick(10);
    trig_i = 1'b0;
  endtask

  task automatic echo_pulse(input int n);
    echo_i = 1'b1;
    tick(n);
    echo_i = 1'b0;
    tick(20);
  endtask

  task automatic measure(input int n);
    trig_pulse();
    tick(20);
    echo_pulse(n);
  endtask

  vec_t        vecs[5];
  logic        m_valid, m_overrun;
  logic [31:0] m_width;
  int unsigned w;
  bit          clr;

  initial begin
    vecs[0] = '{5, 1'b1, 32'd5, 32'h2};
    vecs[1] = '{7, 1'b0, 32'd7, 32'hA};
    vecs[2] = '{1, 1'b1, 32'd1, 32'h2};
    vecs[3] = '{2, 1'b0, 32'd2, 32'hA};
    vecs[4] = '{3, 1'b0, 32'd3, 32'hA};

    tick(5);
    reset = 1'b1;
    tick(2);
    chk("reset_ack", {31'd0, wb_ack_o}, 32'd0);
    chk("reset_intr", {31'd0, intr}, 32'd0);
    rd_chk("reset_status", A_STATUS, 32'h0);
    rd_chk("reset_width", A_WIDTH, 32'h0);
    rd_chk("reset_ctrl", A_CTRL, 32'h0);
    rd_chk("reset_timeout", A_TMO, 32'd3000000);

    wb_write(A_CTRL, 32'h3);
    trig_pulse();
    tick(50);
    echo_pulse(1000);
    rd_chk("basic_width", A_WIDTH, 32'd1000);
    rd_chk("basic_status", A_STATUS, 32'h2);
    chk("basic_intr", {31'd0, intr}, 32'd1);

    wb_write(A_STATUS, 32'hE);
    wb_write(A_TMO, 32'd500);
    wb_write(A_CTRL, 32'h7);
    tick(400);
    rd_chk("tmo_busy", A_STATUS, 32'h1);
    tick(150);
    rd_chk("tmo_status", A_STATUS, 32'h4);
    rd_chk("tmo_width", A_WIDTH, 32'd1000);
    chk("tmo_intr", {31'd0, intr}, 32'd1);

    wb_write(A_STATUS, 32'hE);
    wb_write(A_TMO, 32'd0);
    measure(200);
    measure(300);
    rd_chk("ovr_width", A_WIDTH, 32'd300);
    rd_chk("ovr_status", A_STATUS, 32'hA);
    wb_write(A_STATUS, 32'hE);
    tick(3);
    rd_chk("w1c_status", A_STATUS, 32'h0);
    chk("w1c_intr", {31'd0, intr}, 32'd0);

    for (int i = 0; i < 5; i++) begin
      if (vecs[i].clear) wb_write(A_STATUS, 32'hE);
      measure(vecs[i].width);
      rd_chk($sformatf("vec%0d_width", i), A_WIDTH, vecs[i].exp_width);
      rd_chk($sformatf("vec%0d_status", i), A_STATUS, vecs[i].exp_status);
    end

    wb_write(A_STATUS, 32'hE);
    m_valid = 1'b0; m_overrun = 1'b0; m_width = 32'd3;
    for (int i = 0; i < 8; i++) begin
      w   = $urandom_range(150, 1);
      clr = 1'($urandom_range(1, 0));
      if (clr) begin
        wb_write(A_STATUS, 32'hE);
        m_valid = 1'b0;
        m_overrun = 1'b0;
      end
      measure(w);
      m_overrun = m_overrun | m_valid;
      m_valid   = 1'b1;
      m_width   = w;
      rd_chk($sformatf("rnd%0d_width", i), A_WIDTH, m_width);
      rd_chk($sformatf("rnd%0d_status", i), A_STATUS, {28'd0, m_overrun, 1'b0, m_valid, 1'b0});
    end

    wb_write(A_STATUS, 32'hE);
    trig_pulse();
    tick(20);
    echo_i = 1'b1;
    tick(50);
    wb_write(A_CTRL, 32'h2);
    tick(50);
    echo_i = 1'b0;
    tick(20);
    rd_chk("abort_status", A_STATUS, 32'h0);
    rd_chk("abort_width", A_WIDTH, m_width);

    wb_write(A_CTRL, 32'h3);
    echo_i = 1'b1;
    tick(5);
    trig_pulse();
    tick(30);
    echo_i = 1'b0;
    tick(20);
    rd_chk("prehigh_busy", A_STATUS, 32'h1);
    echo_pulse(60);
    rd_chk("prehigh_width", A_WIDTH, 32'd60);
    rd_chk("prehigh_status", A_STATUS, 32'h2);

    wb_write(A_STATUS, 32'hE);
    trig_pulse();
    tick(20);
    echo_i = 1'b1;
    tick(100);
    reset = 1'b0;
    tick(3);
    reset = 1'b1;
    tick(1);
    chk("rst_intr", {31'd0, intr}, 32'd0);
    rd_chk("rst_status", A_STATUS, 32'h0);
    rd_chk("rst_width", A_WIDTH, 32'h0);
    rd_chk("rst_ctrl", A_CTRL, 32'h0);
    rd_chk("rst_timeout", A_TMO, 32'd3000000);
    tick(880);
    echo_i = 1'b0;
    tick(20);
    wb_write(A_CTRL, 32'h3);
    measure(400);
    rd_chk("post_rst_width", A_WIDTH, 32'd400);
    rd_chk("post_rst_status", A_STATUS, 32'h2);

`ifdef ECHO_GLITCH_FILTER_EN
    wb_write(A_STATUS, 32'hE);
    trig_pulse();
    tick(20);
    echo_i = 1'b1;
    tick(2);
    echo_i = 1'b0;
    tick(20);
    echo_pulse(100);
    rd_chk("filt_width", A_WIDTH, 32'd100);
    rd_chk("filt_status", A_STATUS, 32'h2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
